// File: rtl/ecc_op_scheduler.sv
// ecc_op_scheduler: command-level sequencer for the ECC engines.
// Accepts a single-engine op or a full ECDSA SIGN, pulses the matching engine
// enable for one cycle, waits for that engine's done, retries SIGN from RAND
// when r or s is zero, and reports the outcome with a one-cycle status pulse.
//
// Optional feature: define SCHED_WATCHDOG_EN to build the per-stage WAIT
// watchdog (err 10 after TMO_CYC WAIT cycles). Undefined: WAIT ends only on
// the active done or abort.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_vld, cmd_op      command handshake (op: 000 RAND, 001 INVS, 010 R,
//                        011 S, 101 MMUL, 111 SIGN; 100/110 illegal)
//   cmd_rdy              high only in IDLE
//   abort                terminate the running command (ISSUE/WAIT only)
//   *_done, r_zero, s_zero   engine completion pulses and zero qualifiers
//   en_*                 one-cycle engine start pulses
//   busy, stage          not-IDLE flag and active stage code
//   seq_done, seq_err, err_code, retry_cnt   completion status
module ecc_op_scheduler #(
  parameter int unsigned TMO_CYC   = 4096,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned CNT_W     = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  input  logic [2:0] cmd_op,
  output logic       cmd_rdy,
  input  logic       abort,
  input  logic       rand_done,
  input  logic       mmul_done,
  input  logic       invs_done,
  input  logic       r_done,
  input  logic       s_done,
  input  logic       r_zero,
  input  logic       s_zero,
  output logic       en_rand,
  output logic       en_mmul,
  output logic       en_invs,
  output logic       en_r,
  output logic       en_s,
  output logic       busy,
  output logic [2:0] stage,
  output logic       seq_done,
  output logic       seq_err,
  output logic [1:0] err_code,
  output logic [1:0] retry_cnt
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ERR_W = 2;
  localparam int unsigned RTY_W = 2;
  localparam int unsigned EN_W  = 5;

  localparam logic [OP_W-1:0] OP_RAND = 3'b000;
  localparam logic [OP_W-1:0] OP_INVS = 3'b001;
  localparam logic [OP_W-1:0] OP_R    = 3'b010;
  localparam logic [OP_W-1:0] OP_S    = 3'b011;
  localparam logic [OP_W-1:0] OP_MMUL = 3'b101;
  localparam logic [OP_W-1:0] OP_SIGN = 3'b111;

  localparam logic [ERR_W-1:0] ERR_NONE  = 2'b00;
  localparam logic [ERR_W-1:0] ERR_ILL   = 2'b01;
  localparam logic [ERR_W-1:0] ERR_TMO   = 2'b10;
  localparam logic [ERR_W-1:0] ERR_ABORT = 2'b11;

  // Elaboration-time parameter sanity.
  if (MAX_RETRY >= (32'd1 << RTY_W)) begin : g_bad_retry
    $error("MAX_RETRY does not fit in retry_cnt");
  end
  if (TMO_CYC == 0 || (CNT_W < 32 && TMO_CYC >= (32'd1 << CNT_W))) begin : g_bad_tmo
    $error("TMO_CYC does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   stage_q, stage_d;
  logic              sign_q, sign_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [EN_W-1:0]   en_q, en_d;
  logic              seq_done_q, seq_done_d;
  logic              seq_err_q, seq_err_d;
  logic              act_done_c, zero_hit_c, illegal_c;
`ifdef SCHED_WATCHDOG_EN
  logic [CNT_W-1:0]  wdog_q, wdog_d;
`endif

  // One-hot enable vector for a stage: bit 0 RAND, 1 MMUL, 2 INVS, 3 R, 4 S.
  function automatic logic [EN_W-1:0] stage_en(input logic [OP_W-1:0] st);
    case (st)
      OP_RAND: stage_en = 5'b00001;
      OP_MMUL: stage_en = 5'b00010;
      OP_INVS: stage_en = 5'b00100;
      OP_R:    stage_en = 5'b01000;
      OP_S:    stage_en = 5'b10000;
      default: stage_en = 5'b00000;
    endcase
  endfunction

  // SIGN stage order: RAND -> MMUL -> R -> INVS -> S.
  function automatic logic [OP_W-1:0] next_stage(input logic [OP_W-1:0] st);
    case (st)
      OP_RAND: next_stage = OP_MMUL;
      OP_MMUL: next_stage = OP_R;
      OP_R:    next_stage = OP_INVS;
      OP_INVS: next_stage = OP_S;
      default: next_stage = OP_RAND;
    endcase
  endfunction

  // Only the done of the active stage is meaningful.
  always_comb begin
    act_done_c = 1'b0;
    case (stage_q)
      OP_RAND: act_done_c = rand_done;
      OP_MMUL: act_done_c = mmul_done;
      OP_INVS: act_done_c = invs_done;
      OP_R:    act_done_c = r_done;
      OP_S:    act_done_c = s_done;
      default: act_done_c = 1'b0;
    endcase
  end

  assign zero_hit_c = sign_q && (((stage_q == OP_R) && r_zero) ||
                                 ((stage_q == OP_S) && s_zero));
  assign illegal_c  = (cmd_op == 3'b100) || (cmd_op == 3'b110);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    sign_d  = sign_q;
    err_d   = err_q;
    retry_d = retry_q;
`ifdef SCHED_WATCHDOG_EN
    wdog_d  = wdog_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          retry_d = '0;
          err_d   = ERR_NONE;
          sign_d  = (cmd_op == OP_SIGN);
          stage_d = (cmd_op == OP_SIGN) ? OP_RAND : cmd_op;
          if (illegal_c) begin
            err_d   = ERR_ILL;
            state_d = FIN;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
`ifdef SCHED_WATCHDOG_EN
        wdog_d = '0;
`endif
        if (abort) begin
          err_d   = ERR_ABORT;
          state_d = FIN;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          err_d   = ERR_ABORT;
          state_d = FIN;
        end else if (act_done_c) begin
          if (!sign_q) begin
            state_d = FIN;
          end else if (zero_hit_c) begin
            // Zero r or s: restart from RAND while retries remain.
            if (retry_q < RTY_W'(MAX_RETRY)) begin
              retry_d = retry_q + RTY_W'(1);
              stage_d = OP_RAND;
              state_d = ISSUE;
            end else begin
              err_d   = ERR_ABORT;
              state_d = FIN;
            end
          end else if (stage_q == OP_S) begin
            state_d = FIN;
          end else begin
            stage_d = next_stage(stage_q);
            state_d = ISSUE;
          end
        end
`ifdef SCHED_WATCHDOG_EN
        else if (wdog_q == CNT_W'(TMO_CYC - 1)) begin
          err_d   = ERR_TMO;
          state_d = FIN;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered.
    en_d       = (state_d == ISSUE) ? stage_en(stage_d) : '0;
    seq_done_d = (state_d == FIN);
    seq_err_d  = (state_d == FIN) && (err_d != ERR_NONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      sign_q     <= 1'b0;
      err_q      <= ERR_NONE;
      retry_q    <= '0;
      en_q       <= '0;
      seq_done_q <= 1'b0;
      seq_err_q  <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      sign_q     <= sign_d;
      err_q      <= err_d;
      retry_q    <= retry_d;
      en_q       <= en_d;
      seq_done_q <= seq_done_d;
      seq_err_q  <= seq_err_d;
`ifdef SCHED_WATCHDOG_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign {en_s, en_r, en_invs, en_mmul, en_rand} = en_q;
  assign cmd_rdy   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign stage     = stage_q;
  assign seq_done  = seq_done_q;
  assign seq_err   = seq_err_q;
  assign err_code  = err_q;
  assign retry_cnt = retry_q;

endmodule

// File: doc/ecc_op_scheduler.md
# ecc_op_scheduler

Command-level sequencer for the ECC core engines (random generator, Montgomery multiplier, inverter, r- and s-computation). It accepts a single-engine op or a full ECDSA SIGN command. It issues one-cycle engine enable pulses and waits for each engine's done pulse. On r==0 or s==0 it retries from RAND, and it reports completion or error with one status pulse. It sits between the host command register and the engine enable inputs, in parallel with the input decoder that loads operand RAM.

## Interface
- TMO_CYC, 4096: watchdog limit, in WAIT cycles per stage.
- MAX_RETRY, 3: maximum RAND restarts per SIGN command.
- CNT_W, 13: watchdog counter width; must hold TMO_CYC.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_vld  in  1  command valid.
- cmd_op  in  3  op code: 000 RAND, 001 INVS, 010 R, 011 S, 101 MMUL, 111 SIGN; 100 and 110 are illegal.
- cmd_rdy  out  1  high only in IDLE.
- abort  in  1  terminate the current command.
- rand_done, mmul_done, invs_done, r_done, s_done  in  1 each  engine completion pulses.
- r_zero  in  1  qualifies r_done; computed r is 0.
- s_zero  in  1  qualifies s_done; computed s is 0.
- en_rand, en_mmul, en_invs, en_r, en_s  out  1 each  engine start pulses.
- busy  out  1  state is not IDLE.
- stage  out  3  active stage code, same encoding as cmd_op.
- seq_done  out  1  one-cycle completion pulse.
- seq_err  out  1  valid with seq_done.
- err_code  out  2  valid with seq_done: 00 none, 01 illegal op, 10 timeout, 11 retry exhausted or abort.
- retry_cnt  out  2  retries used by the current or last command.

## Operation
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE: cmd_rdy=1. When cmd_vld is high, latch the op and go to ISSUE.
  - SIGN starts at stage RAND; a single op uses its own stage.
  - An illegal op goes directly to FIN with err 01; no enable is issued.
  - retry_cnt clears on acceptance.
- ISSUE: assert exactly one en_* matching stage for one cycle, clear the watchdog, go to WAIT.
- WAIT: only the done of the active stage counts. Done pulses from other engines, and any done seen during ISSUE, are ignored.
- SIGN stage order: RAND, MMUL, R, INVS, S.
  - r_done with r_zero=1, retry_cnt<MAX_RETRY: retry_cnt+1, stage=RAND, go to ISSUE.
  - r_done with r_zero=1, retry_cnt=MAX_RETRY: FIN with err 11.
  - s_done with s_zero applies the same rule.
  - Any other stage done advances to the next stage via ISSUE.
  - S done with s_zero=0 goes to FIN with no error.
- Single op: active done goes to FIN with no error; r_zero and s_zero are ignored.
- Watchdog: after TMO_CYC WAIT cycles with no active done, go to FIN with err 10.
- abort: in ISSUE or WAIT, go to FIN with err 11; an en_* already issued is not recalled. abort is ignored in IDLE and FIN.
- Priority in the same cycle: abort > active done > timeout.
- FIN: seq_done=1 for one cycle, with seq_err=(err_code!=00). Then go to IDLE.
- Reset values: state IDLE, all en_* 0, seq_done 0, seq_err 0, err_code 00, retry_cnt 0, stage 000, busy 0, cmd_rdy 1.
- Reset mid-command returns to IDLE within one cycle, with no seq_done and no enable.

## Timing
- Acceptance edge T: en_* is high during cycle T+1 (ISSUE). WAIT begins at T+2.
- Active done sampled at edge D: the next stage's en_* is high in cycle D+1, or seq_done is high in cycle D+1.
- Illegal op accepted at edge T: seq_done is high in cycle T+1.
- Timeout: seq_done is high in the cycle after the TMO_CYC-th WAIT cycle.
- Back-to-back commands: cmd_rdy returns in the cycle after seq_done. Minimum spacing between acceptances is 4 cycles (IDLE, ISSUE, WAIT, FIN).
- Registered outputs: en_*, seq_done, seq_err, err_code, retry_cnt, stage. cmd_rdy and busy decode state.

## Configuration
- SCHED_WATCHDOG_EN defined: the watchdog counter and err 10 are implemented as described.
- SCHED_WATCHDOG_EN undefined: no counter is built; WAIT lasts until the active done or abort; err 10 is never produced. TMO_CYC and CNT_W are unused.

## Test plan
- SIGN, each done returned 5 cycles after its enable, r_zero=s_zero=0 -> enables in order RAND, MMUL, R, INVS, S; seq_done with err 00 and retry_cnt 0.
- SIGN with r_zero=1 on the first two r_done pulses -> RAND reissued twice; seq_done with err 00 and retry_cnt 2.
- SIGN with s_zero=1 on every s_done, MAX_RETRY=3 -> 4 S passes; seq_done with seq_err=1 and err 11.
- Single MMUL; rand_done pulsed during WAIT; mmul_done 10 cycles later -> rand_done ignored; seq_done exactly 1 cycle after mmul_done.
- cmd_op=110 -> no en_*; seq_done in the cycle after acceptance with err 01.
- Watchdog enabled, TMO_CYC=16, INVS with no done -> seq_done with err 10 after 16 WAIT cycles.
- Abort during MMUL WAIT -> seq_done with err 11.
- rst during WAIT -> IDLE with no seq_done.
